// File: rtl/debug_uart_tx_fifo.sv
// Buffered debug UART transmitter: small byte FIFO feeding an 8N1 serialiser.
// Latency: write at edge E pops at E+1, start bit drives from E+1; frame is 10*DIV cycles.
// Backpressure: none to the writer; a write to a full FIFO with no pop is dropped and flagged.
module debug_uart_tx_fifo #(
  parameter int CLOCK_MHZ  = 64,
  parameter int BIT_RATE   = 4_000_000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       clr_overflow,
  output logic       uart_txd,
  output logic       tx_busy,
  output logic       fifo_full,
  output logic [3:0] fifo_level,
  output logic       overflow
);

  localparam int DIV = (CLOCK_MHZ * 1_000_000) / BIT_RATE;
  localparam int CW  = (DIV >= 2) ? $clog2(DIV) : 1;
  localparam int AW  = (FIFO_DEPTH >= 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PW  = AW + 1;

  // Reject clock/bit-rate pairs that do not give an integer divider of at least 2.
  if (DIV < 2 || ((CLOCK_MHZ * 1_000_000) % BIT_RATE) != 0) begin : g_bad_div
    $error("debug_uart_tx_fifo: CLOCK_MHZ*1e6/BIT_RATE must be an integer >= 2");
  end
  // Only power-of-two depths 2, 4 and 8 keep the pointer wrap transparent.
  if (FIFO_DEPTH != 2 && FIFO_DEPTH != 4 && FIFO_DEPTH != 8) begin : g_bad_depth
    $error("debug_uart_tx_fifo: FIFO_DEPTH must be 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      sh_q, sh_d;
  logic            txd_q, txd_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            ovf_q, ovf_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic [PW-1:0]   level;
  logic            empty, full, cnt_last, pop, push, drop;

  assign level    = wr_ptr_q - rd_ptr_q;
  assign empty    = (level == '0);
  assign full     = (level == PW'(FIFO_DEPTH));
  assign cnt_last = (cnt_q == CW'(DIV - 1));
  // Pop from IDLE immediately, or on the final stop-bit cycle to chain frames without a gap.
  assign pop      = !empty && ((state_q == IDLE) || (state_q == STOP && cnt_last));
  // A full FIFO still accepts a write when the head leaves in the same cycle.
  assign push     = wr_en && (!full || pop);
  assign drop     = wr_en && full && !pop;

  // FIFO pointers, shifter load and sticky overflow (set beats clear).
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    sh_d     = pop ? mem_q[rd_ptr_q[AW-1:0]] : sh_q;
    ovf_d    = ovf_q;
    if (clr_overflow) ovf_d = 1'b0;
    if (drop)         ovf_d = 1'b1;
  end

  // Next-state logic: bit timer and bit index advance only while a frame is on the line.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (pop) state_d = START;
      end
      START: begin
        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        if (cnt_last) state_d = DATA;
      end
      DATA: begin
        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        if (cnt_last) begin
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        cnt_d = cnt_last ? '0 : cnt_q + CW'(1);
        if (cnt_last) state_d = pop ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level for the coming cycle, taken from the next state so the pin is a plain flop.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = sh_d[idx_d];
      default: txd_d = 1'b1;
    endcase
  end

  // Control state; reset abandons any frame and empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      sh_q     <= '0;
      txd_q    <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      sh_q     <= sh_d;
      txd_q    <= txd_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = (state_q != IDLE) || !empty;
  assign fifo_full  = full;
  assign fifo_level = 4'(level);
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_debug_uart_tx_fifo.sv
// Directed bench for debug_uart_tx_fifo: default instance (DIV=16, depth 4) and a
// small instance (DIV=10, depth 2). A line monitor per instance decodes frames into
// queues; cycle-exact checks cover the single-byte frame.
module tb_debug_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       rst_a, wr_en_a, clr_a;
  logic [7:0] wr_data_a;
  logic       txd_a, busy_a, full_a, ovf_a;
  logic [3:0] level_a;

  logic       rst_b, wr_en_b, clr_b;
  logic [7:0] wr_data_b;
  logic       txd_b, busy_b, full_b, ovf_b;
  logic [3:0] level_b;

  debug_uart_tx_fifo u_dut_a (
    .clk(clk), .rst(rst_a), .wr_en(wr_en_a), .wr_data(wr_data_a), .clr_overflow(clr_a),
    .uart_txd(txd_a), .tx_busy(busy_a), .fifo_full(full_a), .fifo_level(level_a),
    .overflow(ovf_a)
  );

  debug_uart_tx_fifo #(.CLOCK_MHZ(10), .BIT_RATE(1_000_000), .FIFO_DEPTH(2)) u_dut_b (
    .clk(clk), .rst(rst_b), .wr_en(wr_en_b), .wr_data(wr_data_b), .clr_overflow(clr_b),
    .uart_txd(txd_b), .tx_busy(busy_b), .fifo_full(full_b), .fifo_level(level_b),
    .overflow(ovf_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] rxa_b[$];
  int         rxa_s[$];
  logic [7:0] rxb_b[$];
  int         rxb_s[$];
  int         stop_err_a = 0;
  int         stop_err_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic line(input int which);
    return (which == 0) ? txd_a : txd_b;
  endfunction

  function automatic logic [31:0] rx_byte(input int which, input int i);
    if (which == 0) return (i < rxa_b.size()) ? 32'(rxa_b[i]) : 32'hDEAD;
    return (i < rxb_b.size()) ? 32'(rxb_b[i]) : 32'hDEAD;
  endfunction

  function automatic logic [31:0] rx_gap(input int which, input int i);
    if (which == 0) return (i < rxa_s.size()) ? 32'(rxa_s[i] - rxa_s[i-1]) : 32'hDEAD;
    return (i < rxb_s.size()) ? 32'(rxb_s[i] - rxb_s[i-1]) : 32'hDEAD;
  endfunction

  // Frame decoder: sample each bit at its middle, record byte and start cycle.
  task automatic mon(input int which, input int div);
    logic [7:0] b;
    logic       ln;
    int         s;
    forever begin
      @(posedge clk);
      #2;
      if (line(which) === 1'b0) begin
        s = cyc;
        b = '0;
        repeat (div / 2) @(posedge clk);
        #2;
        for (int k = 0; k < 8; k++) begin
          repeat (div) @(posedge clk);
          #2;
          b[k] = line(which);
        end
        repeat (div) @(posedge clk);
        #2;
        ln = line(which);
        if (which == 0) begin
          rxa_b.push_back(b);
          rxa_s.push_back(s);
          if (ln !== 1'b1) stop_err_a++;
        end else begin
          rxb_b.push_back(b);
          rxb_s.push_back(s);
          if (ln !== 1'b1) stop_err_b++;
        end
      end
    end
  endtask

  initial mon(0, 16);
  initial mon(1, 10);

  task automatic push_a(input logic [7:0] d);
    wr_en_a   = 1'b1;
    wr_data_a = d;
    tick();
    wr_en_a   = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    wr_en_b   = 1'b1;
    wr_data_b = d;
    tick();
    wr_en_b   = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, input string tag);
    for (int i = 0; i < budget && busy_a; i++) tick();
    check({tag, "_idle"}, 32'(busy_a), 32'd0);
  endtask

  task automatic wait_idle_b(input int budget, input string tag);
    for (int i = 0; i < budget && busy_b; i++) tick();
    check({tag, "_idle"}, 32'(busy_b), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [3:0] peak;
    logic       any_full, any_busy;
    logic       exp_bit;
    logic [7:0] exp_q[$];

    rst_a = 1'b1; wr_en_a = 1'b0; wr_data_a = 8'h00; clr_a = 1'b0;
    rst_b = 1'b1; wr_en_b = 1'b0; wr_data_b = 8'h00; clr_b = 1'b0;
    tick(); tick(); tick();

    // Reset state
    check("rst_txd", 32'(txd_a), 32'd1);
    check("rst_busy", 32'(busy_a), 32'd0);
    check("rst_full", 32'(full_a), 32'd0);
    check("rst_level", 32'(level_a), 32'd0);
    check("rst_ovf", 32'(ovf_a), 32'd0);
    check("rst_b_txd", 32'(txd_b), 32'd1);
    check("rst_b_level", 32'(level_b), 32'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;
    tick();

    // Single byte 0x55, cycle-exact
    b = 8'h55;
    push_a(b);                                   // edge E
    check("single_level_E", 32'(level_a), 32'd1);
    check("single_busy_E", 32'(busy_a), 32'd1);
    check("single_txd_E", 32'(txd_a), 32'd1);
    tick();                                      // edge E+1
    check("single_level_E1", 32'(level_a), 32'd0);
    for (int j = 0; j < 160; j++) begin
      if (j > 0) tick();
      if (j < 16)       exp_bit = 1'b0;
      else if (j < 144) exp_bit = b[(j - 16) / 16];
      else              exp_bit = 1'b1;
      check("single_txd", 32'(txd_a), 32'(exp_bit));
    end
    check("single_busy_E160", 32'(busy_a), 32'd1);
    tick();                                      // edge E+161
    check("single_busy_E161", 32'(busy_a), 32'd0);
    check("single_txd_E161", 32'(txd_a), 32'd1);
    check("single_count", 32'(rxa_b.size()), 32'd1);
    check("single_byte", rx_byte(0, 0), 32'h55);

    // Burst of four
    rxa_b.delete(); rxa_s.delete();
    peak = '0; any_full = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_a(8'h41 + 8'(i));
      if (level_a > peak) peak = level_a;
      any_full |= full_a;
    end
    for (int i = 0; i < 800 && busy_a; i++) begin
      tick();
      if (level_a > peak) peak = level_a;
      any_full |= full_a;
    end
    check("burst_idle", 32'(busy_a), 32'd0);
    check("burst_peak", 32'(peak), 32'd3);
    check("burst_full", 32'(any_full), 32'd0);
    check("burst_count", 32'(rxa_b.size()), 32'd4);
    for (int i = 0; i < 4; i++) check("burst_byte", rx_byte(0, i), 32'h41 + 32'(i));
    for (int i = 1; i < 4; i++) check("burst_gap", rx_gap(0, i), 32'd160);

    // Overflow
    rxa_b.delete(); rxa_s.delete();
    for (int i = 0; i < 5; i++) push_a(8'h10 + 8'(i));
    check("ovf_full", 32'(full_a), 32'd1);
    check("ovf_level4", 32'(level_a), 32'd4);
    check("ovf_before", 32'(ovf_a), 32'd0);
    push_a(8'h15);
    check("ovf_set", 32'(ovf_a), 32'd1);
    check("ovf_level_kept", 32'(level_a), 32'd4);
    clr_a = 1'b1;
    tick();
    clr_a = 1'b0;
    check("ovf_clr", 32'(ovf_a), 32'd0);
    wait_idle_a(1200, "ovf");
    check("ovf_count", 32'(rxa_b.size()), 32'd5);
    for (int i = 0; i < 5; i++) check("ovf_byte", rx_byte(0, i), 32'h10 + 32'(i));

    // Full FIFO plus write on the pop cycle
    rxa_b.delete(); rxa_s.delete();
    for (int i = 0; i < 5; i++) push_a(8'hA0 + 8'(i));   // edges E..E+4
    repeat (156) tick();                                // edge E+160
    check("fpp_level_pre", 32'(level_a), 32'd4);
    push_a(8'h99);                                      // edge E+161, pop edge
    check("fpp_level", 32'(level_a), 32'd4);
    check("fpp_ovf", 32'(ovf_a), 32'd0);
    check("fpp_full", 32'(full_a), 32'd1);
    wait_idle_a(1200, "fpp");
    exp_q = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'h99};
    check("fpp_count", 32'(rxa_b.size()), 32'd6);
    for (int i = 0; i < 6; i++) check("fpp_byte", rx_byte(0, i), 32'(exp_q[i]));

    // Reset in the middle of a frame
    push_a(8'hA5);                                      // edge E
    push_a(8'h01);                                      // edge E+1 (pops A5)
    push_a(8'h02);                                      // edge E+2
    check("mid_level", 32'(level_a), 32'd2);
    repeat (67) tick();                                 // edge E+69, data bit 3
    check("mid_bit3", 32'(txd_a), 32'd0);
    rst_a = 1'b1;
    tick();                                             // edge E+70
    check("mid_rst_txd", 32'(txd_a), 32'd1);
    check("mid_rst_level", 32'(level_a), 32'd0);
    check("mid_rst_busy", 32'(busy_a), 32'd0);
    rst_a = 1'b0;
    any_busy = 1'b0;
    repeat (150) begin
      tick();
      any_busy |= busy_a;
    end
    rxa_b.delete(); rxa_s.delete();
    repeat (400) begin
      tick();
      any_busy |= busy_a;
    end
    check("mid_no_busy", 32'(any_busy), 32'd0);
    check("mid_no_frames", 32'(rxa_b.size()), 32'd0);

    // Small instance: DIV=10, depth 2
    push_b(8'hB0);                                      // starts a frame
    push_b(8'hC1);
    push_b(8'hC2);
    check("b_full", 32'(full_b), 32'd1);
    check("b_ovf_pre", 32'(ovf_b), 32'd0);
    push_b(8'hC3);
    check("b_ovf", 32'(ovf_b), 32'd1);
    check("b_level", 32'(level_b), 32'd2);
    wait_idle_b(600, "b");
    check("b_count", 32'(rxb_b.size()), 32'd3);
    check("b_byte0", rx_byte(1, 0), 32'hB0);
    check("b_byte1", rx_byte(1, 1), 32'hC1);
    check("b_byte2", rx_byte(1, 2), 32'hC2);
    check("b_gap1", rx_gap(1, 1), 32'd100);
    check("b_gap2", rx_gap(1, 2), 32'd100);

    check("stop_bits_a", 32'(stop_err_a), 32'd0);
    check("stop_bits_b", 32'(stop_err_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
